// File: rtl/inst_fetch_resp_if.sv
// Fetch request and decode-side response bundle for inst_fetch_resp.
// The master is the PC/decode side and the slave is the responder.
interface inst_fetch_resp_if;
  logic [31:0] pc;
  logic        ce;
  logic        req_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_misalign;
  logic        inst_valid;
  logic        inst_ready;

  modport master (
    output pc, ce, inst_ready,
    input  req_ready, inst, inst_pc, inst_misalign, inst_valid
  );

  modport slave (
    input  pc, ce, inst_ready,
    output req_ready, inst, inst_pc, inst_misalign, inst_valid
  );
endinterface

// File: rtl/inst_fetch_resp.sv
// Instruction fetch responder: synchronous imem read, one pipeline stage,
// and a credit-managed output FIFO towards decode.
module inst_fetch_resp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  inst_fetch_resp_if.slave      bus,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [31:0]           wr_data,
  input  logic                  flush
);
  localparam int MD = 1 << DEPTH_LOG2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

  logic [31:0] mem_q [0:MD-1];
  logic [31:0] rdata_q;

  logic        rst_q;
  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_pc_q, s1_pc_d;
  logic        s1_mis_q, s1_mis_d;

  logic [31:0] f_inst_q [0:FIFO_DEPTH-1];
  logic [31:0] f_pc_q   [0:FIFO_DEPTH-1];
  logic        f_mis_q  [0:FIFO_DEPTH-1];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW:0]   occ;

  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [DEPTH_LOG2-1:0] raddr;

  assign raddr  = bus.pc[DEPTH_LOG2+1:2];
  assign accept = bus.ce && bus.req_ready && !flush;
  assign push   = s1_valid_q;
  assign pop    = bus.inst_valid && bus.inst_ready;

  // Credit counts the S1 entry so a push can never hit a full FIFO.
  assign occ           = {1'b0, count_q} + {{CW{1'b0}}, s1_valid_q};
  assign bus.req_ready = !rst_q && (occ < DEPTH_C);

  assign bus.inst_valid    = (count_q != '0);
  assign bus.inst          = bus.inst_valid ? f_inst_q[rd_ptr_q] : '0;
  assign bus.inst_pc       = bus.inst_valid ? f_pc_q[rd_ptr_q] : '0;
  assign bus.inst_misalign = bus.inst_valid && f_mis_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (accept) begin
      rdata_q <= mem_q[raddr];
    end
  end

  always_comb begin
    s1_valid_d = accept;
    s1_pc_d    = s1_pc_q;
    s1_mis_d   = s1_mis_q;
    if (accept) begin
      s1_pc_d  = bus.pc;
      s1_mis_d = |bus.pc[1:0];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + {{PW{1'b0}}, push}
                        - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_pc_q    <= '0;
      s1_mis_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_pc_q    <= s1_pc_d;
      s1_mis_q   <= s1_mis_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Misaligned fetches turn into a NOP flagged for the decoder to trap on.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      f_inst_q[wr_ptr_q] <= s1_mis_q ? 32'h0 : rdata_q;
      f_pc_q[wr_ptr_q]   <= s1_pc_q;
      f_mis_q[wr_ptr_q]  <= s1_mis_q;
    end
  end
endmodule

// File: tb/tb_inst_fetch_resp.sv
// Scoreboard bench for inst_fetch_resp: driver queues hand-computed
// responses on accept, a monitor compares them on every pop.
module tb_inst_fetch_resp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        flush = 1'b0;

  inst_fetch_resp_if bus();

  inst_fetch_resp #(.DEPTH_LOG2(10), .FIFO_DEPTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .flush  (flush)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.inst_valid && bus.inst_ready) begin
      if (q.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_out: got inst %h pc %h want none",
                 bus.inst, bus.inst_pc);
      end else begin
        e = q.pop_front();
        chk("sb_inst", bus.inst, e.inst);
        chk("sb_pc", bus.inst_pc, e.pc);
        chk("sb_mis", {31'b0, bus.inst_misalign}, {31'b0, e.mis});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d,
                     input logic m);
    bit done;
    done = 1'b0;
    bus.ce = 1'b1;
    bus.pc = a;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.req_ready && !flush && !rst) begin
        q.push_back('{inst: d, pc: a, mis: m});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.ce = 1'b0;
    if (!done) begin
      n_tot++;
      $display("FAIL req_timeout: pc %h got no accept want accept", a);
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((q.size() != 0 || bus.inst_valid) && i < 40) begin
      step();
      i++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  task automatic chk_zero_out(input string nm);
    chk({nm, "_valid"}, {31'b0, bus.inst_valid}, 32'h0);
    chk({nm, "_inst"}, bus.inst, 32'h0);
    chk({nm, "_pc"}, bus.inst_pc, 32'h0);
    chk({nm, "_mis"}, {31'b0, bus.inst_misalign}, 32'h0);
    chk({nm, "_rdy0"}, {31'b0, bus.req_ready}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.ce = 1'b0;
    bus.pc = '0;
    bus.inst_ready = 1'b1;
    step();
    step();
    chk_zero_out("reset");
    rst = 1'b0;
    step();
    chk("reset_rdy1", {31'b0, bus.req_ready}, 32'h1);

    wr(10'd0, 32'h11111111);
    wr(10'd1, 32'h22222222);
    wr(10'd2, 32'h33333333);
    wr(10'd3, 32'h44444444);
    wr(10'd4, 32'h55555555);
    wr(10'd5, 32'h66666666);
    wr(10'd6, 32'h77777777);
    wr(10'd7, 32'h88888888);

    // load and stream, latency 2
    req(32'h0, 32'h11111111, 1'b0);
    chk("lat_t1", {31'b0, bus.inst_valid}, 32'h0);
    req(32'h4, 32'h22222222, 1'b0);
    chk("lat_t2", {31'b0, bus.inst_valid}, 32'h1);
    chk("lat_t2_inst", bus.inst, 32'h11111111);
    req(32'h8, 32'h33333333, 1'b0);
    drain();

    // back-pressure
    bus.inst_ready = 1'b0;
    req(32'h0, 32'h11111111, 1'b0);
    req(32'h4, 32'h22222222, 1'b0);
    req(32'h8, 32'h33333333, 1'b0);
    req(32'hC, 32'h44444444, 1'b0);
    bus.ce = 1'b1;
    bus.pc = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_full_rdy", {31'b0, bus.req_ready}, 32'h0);
      @(posedge clk);
      #1;
    end
    bus.ce = 1'b0;
    bus.inst_ready = 1'b1;
    chk("bp_release_rdy", {31'b0, bus.req_ready}, 32'h0);
    step();
    chk("bp_rise_rdy", {31'b0, bus.req_ready}, 32'h1);
    drain();

    // misaligned
    req(32'h6, 32'h0, 1'b1);
    drain();

    // wrap and read-first
    req(32'h1000, 32'h11111111, 1'b0);
    wr_en = 1'b1;
    wr_addr = 10'd5;
    wr_data = 32'hAAAAAAAA;
    req(32'h14, 32'h66666666, 1'b0);
    wr_en = 1'b0;
    req(32'h14, 32'hAAAAAAAA, 1'b0);
    drain();

    // flush with three buffered and one in S1
    bus.inst_ready = 1'b0;
    req(32'h0, 32'h11111111, 1'b0);
    req(32'h4, 32'h22222222, 1'b0);
    req(32'h8, 32'h33333333, 1'b0);
    req(32'hC, 32'h44444444, 1'b0);
    flush = 1'b1;
    bus.ce = 1'b1;
    bus.pc = 32'h18;
    bus.inst_ready = 1'b1;
    @(posedge clk);
    q.delete();
    #1;
    flush = 1'b0;
    bus.ce = 1'b0;
    chk("flush_valid", {31'b0, bus.inst_valid}, 32'h0);
    chk("flush_rdy", {31'b0, bus.req_ready}, 32'h1);
    req(32'h1C, 32'h88888888, 1'b0);
    drain();

    // reset mid-stream
    bus.inst_ready = 1'b0;
    req(32'h0, 32'h11111111, 1'b0);
    req(32'h4, 32'h22222222, 1'b0);
    req(32'h8, 32'h33333333, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    q.delete();
    #1;
    rst = 1'b0;
    bus.inst_ready = 1'b1;
    chk_zero_out("midrst");
    step();
    chk("midrst_rdy1", {31'b0, bus.req_ready}, 32'h1);
    req(32'h8, 32'h33333333, 1'b0);
    req(32'h14, 32'hAAAAAAAA, 1'b0);
    drain();
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
